// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard and a
// post-reset clear walk that zeroes the array before normal operation.
module regfile_mp #(
    parameter  int XLEN   = 64,
    parameter  int NREG   = 32,
    parameter  int NRD    = 2,
    parameter  int NWR    = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                init_done,
    input  logic [NRD-1:0]      re,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    input  logic                sb_flush
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   clr_idx, clr_idx_nxt;
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] wr_hit;
    logic [XLEN-1:0] wr_val [NREG];
    logic            run;

    assign run       = (state == RUN);
    assign init_done = run;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        if (state == CLEAR) begin
            clr_idx_nxt = clr_idx + AW'(1);
            if (clr_idx == AW'(NREG - 1))
                state_nxt = RUN;
        end
    end

    // Per-register write decode; scanning ports upward lets the highest-index
    // port overwrite lower ones on an address collision.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            wr_hit[r] = 1'b0;
            wr_val[r] = '0;
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && waddr[j*AW +: AW] == AW'(r)) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wdata[j*XLEN +: XLEN];
                end
            end
        end
        wr_hit[0] = 1'b0;
    end

    // Array has no reset of its own; the clear walk zeroes it instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) begin
                regs[clr_idx] <= '0;
            end else begin
                for (int r = 0; r < NREG; r++)
                    if (wr_hit[r])
                        regs[r] <= wr_val[r];
            end
        end
    end

    // Alloc is applied after write-clears so it wins on the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else if (run) begin
            if (sb_flush) begin
                busy <= '0;
            end else begin
                for (int r = 0; r < NREG; r++)
                    if (wr_hit[r])
                        busy[r] <= 1'b0;
                if (alloc_en && alloc_addr != '0)
                    busy[alloc_addr] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = raddr[i*AW +: AW];

        always_comb begin
            rdata[i*XLEN +: XLEN] = '0;
            rbusy[i]              = 1'b0;
            if (run && re[i] && ra != '0) begin
                if (BYPASS != 0 && wr_hit[ra]) begin
                    rdata[i*XLEN +: XLEN] = wr_val[ra];
                end else begin
                    rdata[i*XLEN +: XLEN] = regs[ra];
                    rbusy[i]              = busy[ra];
                end
            end
        end
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with per-register busy scoreboard and a post-reset clear sequencer. It replaces the single-write, two-read register file in the core's decode/writeback path so that dual-issue and out-of-order-completing units can share one architectural register set. Reads are combinational with optional same-cycle write bypass. Writes, scoreboard updates and clearing are synchronous to clk.

## Interface
- XLEN, 64, register width in bits
- NREG, 32, number of registers, power of two, ≥ 2
- NRD, 2, number of read ports
- NWR, 2, number of write ports
- BYPASS, 1, 1 = read returns same-cycle write data; 0 = read returns array contents
- AW, $clog2(NREG), address width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- init_done  out  1  high once the clear sequence has finished
- re  in  NRD  per-port read enable
- raddr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- rdata  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
- rbusy  out  NRD  port i's register has a pending producer
- we  in  NWR  per-port write enable
- waddr  in  NWR*AW  write addresses
- wdata  in  NWR*XLEN  write data
- alloc_en  in  1  mark alloc_addr as having a pending producer
- alloc_addr  in  AW  register being allocated
- sb_flush  in  1  clear all busy bits (pipeline flush)

## Operation
- FSM states: CLEAR, RUN. rst forces CLEAR with clr_idx = 0. CLEAR writes 0 to regs[clr_idx] each cycle and increments clr_idx. After the cycle that writes NREG-1, the FSM moves to RUN. CLEAR never returns except through rst.
- In CLEAR, the block ignores we, alloc_en and sb_flush. Outputs: rdata = 0, rbusy = 0, init_done = 0. All busy bits are held at 0.
- Register 0 is hardwired zero:
  - writes to address 0 are dropped
  - allocating address 0 has no effect
  - a read of address 0 returns 0 with rbusy = 0
- Write arbitration: when several enabled write ports target the same address in one cycle, the highest-index port wins. The lower-index writes to that address are discarded.
- Read port i, evaluated in priority order:
  1. re[i] = 0 gives rdata 0, rbusy 0.
  2. Address 0 gives rdata 0, rbusy 0.
  3. If BYPASS = 1 and an enabled write targets the same address this cycle, rdata = winning wdata and rbusy = 0.
  4. Otherwise rdata = regs[raddr], and rbusy = busy[raddr].
- Scoreboard, one busy bit per register, updated at the clock edge:
  - An enabled write to address a clears busy[a].
  - alloc_en sets busy[alloc_addr].
  - If an alloc and a write target the same address in the same cycle, the alloc wins and the bit ends set.
  - sb_flush clears every bit and overrides an alloc in the same cycle.
  - Writes still update the array during a flush.

## Timing
- Reset: rst sampled high at an edge gives, after that edge:
  - FSM = CLEAR, clr_idx = 0
  - all busy bits = 0
  - init_done = 0, rdata = 0, rbusy = 0
- Array contents are not cleared by rst itself; they are cleared only by the CLEAR walk.
- Clear length: NREG cycles after rst deasserts. init_done rises on the edge that completes the last clear write and stays high until the next rst.
- rst asserted mid-CLEAR restarts the walk from index 0.
- rst asserted in RUN discards any writes and allocs issued in that cycle.
- Write latency:
  - Visible through the array on the cycle after the write edge.
  - With BYPASS = 1, also visible combinationally in the same cycle.
- Scoreboard latency: rbusy reflects an alloc from the cycle after alloc_en. It drops in the write cycle itself if BYPASS = 1, otherwise on the following cycle.
- Read paths are purely combinational from raddr/re/we/waddr/wdata to rdata/rbusy, with no state in the path.

## Test plan
- Reset and clear with NREG = 32:
  - hold rst for 1 cycle, then release
  - init_done rises exactly 32 cycles later
  - every read returns 0 during the walk and after it
- Basic write/read: write 0xDEADBEEF_00000001 to x5 via port 0.
  - In the same cycle, read x5 on port 1 and expect that value (BYPASS = 1).
  - With BYPASS = 0, expect the old value that cycle and the new value the next cycle.
- Write conflict: in one cycle, port 0 writes 0x1 and port 1 writes 0x2, both to x7. The next cycle x7 reads 0x2.
- Register 0: write 0xFFFF to x0 and alloc x0. Reads of x0 return 0 with rbusy = 0.
- Scoreboard:
  - alloc x9 → rbusy = 1 the next cycle
  - write x9 with 0x55 → rbusy = 0 and rdata = 0x55 that cycle
  - alloc and write x9 in the same cycle → rbusy = 1 afterwards
  - sb_flush → all rbusy = 0
- Reset mid-clear: assert rst at clear cycle 10. init_done stays low and rises 32 cycles after rst is released.
